mips_multicycle_core: RTL and testbench

MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

---
 rtl/mips_multicycle_core.sv | 236 +++++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// Purpose: multicycle MIPS subset core (add/sub/and/or/slt, lw, sw, beq, addi, j) on one memory port.
// Latency: beq/j 3 cycles, R-type/addi/sw 4 cycles, lw 5 cycles, plus any memory wait states.
// Backpressure: stalls in FETCH/MEM holding request fields stable until mem_ack; one transaction at a time.
module mips_multicycle_core #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              clr_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    state_t            cur_state;
    state_t            nxt_state;

    logic [31:0]       ir;
    logic [31:0]       a_reg;
    logic [31:0]       b_reg;
    logic [31:0]       alu_out;
    logic [31:0]       mdr;
    logic [ADDR_W-1:0] pc_reg;
    logic [31:0]       rf [32];

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [31:0]       sext_imm;
    logic [31:0]       br_off;
    logic [31:0]       jmp_tgt;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] pc_plus4;
    logic [31:0]       rf_a;
    logic [31:0]       rf_b;
    logic [31:0]       alu_r;
    logic              supported;
    logic [4:0]        wb_addr;
    logic [31:0]       wb_data;
    logic              req_raw;

    // Bits that only matter for wide address configurations are folded here.
    logic              unused_bits;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign sext_imm = {{16{ir[15]}}, ir[15:0]};
    assign br_off   = {sext_imm[29:0], 2'b00};
    assign jmp_tgt  = {4'b0000, ir[25:0], 2'b00};
    assign br_tgt   = pc_reg + br_off[ADDR_W-1:0];
    assign pc_plus4 = pc_reg + ADDR_W'(4);

    // $0 is hardwired to zero on the read side as well as the write side.
    assign rf_a = (rs == 5'd0) ? 32'h0 : rf[rs];
    assign rf_b = (rt == 5'd0) ? 32'h0 : rf[rt];

    // R-type writes rd, loads and addi write rt; only lw takes the loaded word.
    assign wb_addr = (op == OP_RTYPE) ? rd : rt;
    assign wb_data = (op == OP_LW) ? mdr : alu_out;

    assign pc          = pc_reg;
    assign state       = cur_state;
    assign halted      = (cur_state == S_HALT);
    assign unused_bits = ^{alu_out, jmp_tgt, br_off};

    // Request is suppressed while reset is held so a reset FETCH state does not present a request.
    assign mem_req = req_raw & clr_n;

    // Decode check: anything outside the supported subset stops the core.
    always_comb begin
        supported = 1'b0;
        case (op)
            OP_RTYPE: supported = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: supported = 1'b1;
            default: supported = 1'b0;
        endcase
    end

    // R-type ALU; add/sub wrap modulo 2^32, slt is signed.
    always_comb begin
        alu_r = 32'h0;
        case (funct)
            FN_ADD:  alu_r = a_reg + b_reg;
            FN_SUB:  alu_r = a_reg - b_reg;
            FN_AND:  alu_r = a_reg & b_reg;
            FN_OR:   alu_r = a_reg | b_reg;
            FN_SLT:  alu_r = {31'h0, ($signed(a_reg) < $signed(b_reg))};
            default: alu_r = 32'h0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // FSM next state and memory port drive; request fields derive only from held registers.
    always_comb begin
        nxt_state = cur_state;
        req_raw   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_reg;
        mem_wdata = 32'h0;
        case (cur_state)
            S_FETCH: begin
                req_raw = 1'b1;
                if (mem_ack) begin
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                nxt_state = supported ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                case (op)
                    OP_RTYPE, OP_ADDI: nxt_state = S_WB;
                    OP_LW, OP_SW:      nxt_state = S_MEM;
                    OP_BEQ, OP_J:      nxt_state = S_FETCH;
                    default:           nxt_state = S_HALT;
                endcase
            end
            S_MEM: begin
                req_raw   = 1'b1;
                mem_we    = (op == OP_SW);
                mem_addr  = alu_out[ADDR_W-1:0];
                mem_wdata = b_reg;
                if (mem_ack) begin
                    nxt_state = (op == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                nxt_state = S_FETCH;
            end
            S_HALT: begin
                nxt_state = S_HALT;
            end
            default: begin
                nxt_state = S_HALT;
            end
        endcase
    end

    // Datapath registers: IR/PC on fetch, operands and branch target on decode, ALU/PC in exec, MDR on load.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ir      <= 32'h0;
            a_reg   <= 32'h0;
            b_reg   <= 32'h0;
            alu_out <= 32'h0;
            mdr     <= 32'h0;
            pc_reg  <= RESET_PC[ADDR_W-1:0];
        end else begin
            case (cur_state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir     <= mem_rdata;
                        pc_reg <= pc_plus4;
                    end
                end
                S_DECODE: begin
                    a_reg   <= rf_a;
                    b_reg   <= rf_b;
                    alu_out <= 32'(br_tgt);
                end
                S_EXEC: begin
                    case (op)
                        OP_RTYPE:             alu_out <= alu_r;
                        OP_ADDI, OP_LW, OP_SW: alu_out <= a_reg + sext_imm;
                        OP_BEQ: begin
                            if (a_reg == b_reg) begin
                                pc_reg <= alu_out[ADDR_W-1:0];
                            end
                        end
                        OP_J:                 pc_reg <= jmp_tgt[ADDR_W-1:0];
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack && (op == OP_LW)) begin
                        mdr <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file: cleared by reset, single write port in WB, $0 writes dropped.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'h0;
            end
        end else if ((cur_state == S_WB) && (wb_addr != 5'd0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Purpose: directed scenarios against a bench memory model with fetch/write scoreboards.
// Latency: measured as cycles between successive instruction fetch completions.
// Backpressure: the memory model inserts configurable wait states and spurious acks.
module tb_mips_multicycle_core;

    localparam int ADDR_W = 8;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic              clk = 1'b0;
    logic              clr_n = 1'b0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;
    logic              mem_ack = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        state;
    logic              halted;

    mips_multicycle_core #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc        (pc),
        .state     (state),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    // Observed (memory model) and expected (test) queues.
    logic [7:0]  fa_q[$];
    int          fc_q[$];
    logic [39:0] wr_q[$];
    logic [7:0]  exp_fa_q[$];
    int          exp_lat_q[$];
    logic [39:0] exp_wr_q[$];

    int          data_delay = 0;
    bit          spurious = 1'b0;
    int          wcnt = 0;
    int          dly = 0;
    int          unstable = 0;
    int          waits = 0;
    logic [7:0]  h_addr;
    logic        h_we;
    logic [31:0] h_wdata;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(int tgt);
        return {6'h02, 26'(tgt)};
    endfunction

    // Memory model: answers on the falling edge, the core consumes on the next rising edge.
    always @(negedge clk) begin
        if (!clr_n) begin
            mem_ack = 1'b0;
            wcnt = 0;
            unstable = 0;
            waits = 0;
            fa_q.delete();
            fc_q.delete();
            wr_q.delete();
        end else begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt = 0;
            end
            if (mem_req) begin
                dly = (state == 3'd0) ? 0 : data_delay;
                if (wcnt == 0) begin
                    h_addr = mem_addr;
                    h_we = mem_we;
                    h_wdata = mem_wdata;
                end else if (mem_addr !== h_addr || mem_we !== h_we || (h_we && mem_wdata !== h_wdata)) begin
                    unstable++;
                end
                if (wcnt >= dly) begin
                    mem_ack = 1'b1;
                    if (state == 3'd0) begin
                        mem_rdata = imem[mem_addr[7:2]];
                        fa_q.push_back(mem_addr);
                        fc_q.push_back(cyc + 1);
                    end else if (mem_we) begin
                        wr_q.push_back({mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = dmem[mem_addr[7:2]];
                    end
                end else begin
                    wcnt++;
                    waits++;
                end
            end else if (spurious) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hFFFF_FFFF;
            end
        end
    end

    // Hold the core in reset and clear memories and expectations.
    task automatic prep();
        @(negedge clk);
        clr_n = 1'b0;
        for (int i = 0; i < 64; i++) begin
            imem[i] = HALT_W;
            dmem[i] = 32'h0;
        end
        exp_fa_q.delete();
        exp_lat_q.delete();
        exp_wr_q.delete();
        data_delay = 0;
        spurious = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 clr_n = 1'b1;
    endtask

    task automatic test_reset();
        prep();
        repeat (2) @(posedge clk);
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_req); end
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL rst_pc got=%h want=00", pc); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", halted); end
        release_reset();
        #1;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rel_req got=%b want=1", mem_req); end
        total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL rel_addr got=%h want=00", mem_addr); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rel_we got=%b want=0", mem_we); end
        @(posedge clk);
        #1;
        total++; if (state !== 3'd1) begin bad++; $display("FAIL first_edge_state got=%0d want=1", state); end
        total++; if (pc !== 8'h04) begin bad++; $display("FAIL first_edge_pc got=%h want=04", pc); end
    endtask

    task automatic test_alu();
        logic [31:0] prog [19];
        logic [39:0] e;
        logic [39:0] o;
        prep();
        prog[0]  = enc_i(6'h08, 0, 1, 5);
        prog[1]  = enc_i(6'h08, 0, 2, -3);
        prog[2]  = enc_r(1, 2, 3, 6'h20);
        prog[3]  = enc_i(6'h2B, 0, 3, 16);
        prog[4]  = enc_r(1, 2, 5, 6'h22);
        prog[5]  = enc_i(6'h2B, 0, 5, 20);
        prog[6]  = enc_r(1, 2, 6, 6'h24);
        prog[7]  = enc_i(6'h2B, 0, 6, 24);
        prog[8]  = enc_r(1, 2, 7, 6'h25);
        prog[9]  = enc_i(6'h2B, 0, 7, 28);
        prog[10] = enc_r(2, 1, 8, 6'h2A);
        prog[11] = enc_i(6'h2B, 0, 8, 32);
        prog[12] = enc_r(1, 2, 9, 6'h2A);
        prog[13] = enc_i(6'h2B, 0, 9, 36);
        prog[14] = enc_r(0, 1, 10, 6'h22);
        prog[15] = enc_i(6'h2B, 0, 10, 40);
        prog[16] = enc_i(6'h08, 10, 12, 6);
        prog[17] = enc_i(6'h2B, 0, 12, 44);
        prog[18] = HALT_W;
        for (int i = 0; i < 19; i++) begin
            imem[i] = prog[i];
            exp_fa_q.push_back(8'(i * 4));
            if (i < 18) exp_lat_q.push_back(4);
        end
        exp_wr_q.push_back({8'h10, 32'h0000_0002});
        exp_wr_q.push_back({8'h14, 32'h0000_0008});
        exp_wr_q.push_back({8'h18, 32'h0000_0005});
        exp_wr_q.push_back({8'h1C, 32'hFFFF_FFFD});
        exp_wr_q.push_back({8'h20, 32'h0000_0001});
        exp_wr_q.push_back({8'h24, 32'h0000_0000});
        exp_wr_q.push_back({8'h28, 32'hFFFF_FFFB});
        exp_wr_q.push_back({8'h2C, 32'h0000_0001});
        release_reset();
        for (int i = 0; i < 400 && !halted; i++) begin @(posedge clk); #1; end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL alu_timeout halted=%b want=1", halted); end
        for (int i = 0; i < exp_fa_q.size(); i++) begin
            total++;
            if (i >= fa_q.size()) begin bad++; $display("FAIL alu_fetch[%0d] got=none want=%h", i, exp_fa_q[i]); end
            else if (fa_q[i] !== exp_fa_q[i]) begin bad++; $display("FAIL alu_fetch[%0d] got=%h want=%h", i, fa_q[i], exp_fa_q[i]); end
        end
        for (int i = 0; i < exp_lat_q.size(); i++) begin
            total++;
            if (i + 1 >= fc_q.size()) begin bad++; $display("FAIL alu_lat[%0d] got=none want=%0d", i, exp_lat_q[i]); end
            else if (fc_q[i+1] - fc_q[i] != exp_lat_q[i]) begin bad++; $display("FAIL alu_lat[%0d] got=%0d want=%0d", i, fc_q[i+1] - fc_q[i], exp_lat_q[i]); end
        end
        while (exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            total++;
            if (wr_q.size() == 0) begin bad++; $display("FAIL alu_write got=none want=%h", e); end
            else begin
                o = wr_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL alu_write got=%h want=%h", o, e); end
            end
        end
        total++; if (wr_q.size() != 0) begin bad++; $display("FAIL alu_extra_writes got=%0d want=0", wr_q.size()); end
    endtask

    task automatic test_lw_wait();
        logic [39:0] o;
        prep();
        data_delay = 3;
        spurious = 1'b1;
        dmem[0] = 32'hDEAD_BEEF;
        imem[0] = enc_i(6'h23, 0, 4, 0);
        imem[1] = enc_i(6'h2B, 0, 4, 64);
        exp_fa_q.push_back(8'h00);
        exp_fa_q.push_back(8'h04);
        exp_fa_q.push_back(8'h08);
        exp_lat_q.push_back(8);
        exp_lat_q.push_back(7);
        exp_wr_q.push_back({8'h40, 32'hDEAD_BEEF});
        release_reset();
        for (int i = 0; i < 200 && !halted; i++) begin @(posedge clk); #1; end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL lw_timeout halted=%b want=1", halted); end
        for (int i = 0; i < exp_fa_q.size(); i++) begin
            total++;
            if (i >= fa_q.size()) begin bad++; $display("FAIL lw_fetch[%0d] got=none want=%h", i, exp_fa_q[i]); end
            else if (fa_q[i] !== exp_fa_q[i]) begin bad++; $display("FAIL lw_fetch[%0d] got=%h want=%h", i, fa_q[i], exp_fa_q[i]); end
        end
        for (int i = 0; i < exp_lat_q.size(); i++) begin
            total++;
            if (i + 1 >= fc_q.size()) begin bad++; $display("FAIL lw_lat[%0d] got=none want=%0d", i, exp_lat_q[i]); end
            else if (fc_q[i+1] - fc_q[i] != exp_lat_q[i]) begin bad++; $display("FAIL lw_lat[%0d] got=%0d want=%0d", i, fc_q[i+1] - fc_q[i], exp_lat_q[i]); end
        end
        total++;
        if (wr_q.size() == 0) begin bad++; $display("FAIL lw_write got=none want=%h", exp_wr_q[0]); end
        else begin
            o = wr_q.pop_front();
            if (o !== exp_wr_q[0]) begin bad++; $display("FAIL lw_write got=%h want=%h", o, exp_wr_q[0]); end
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL lw_hold_stable changes=%0d want=0", unstable); end
        total++; if (waits != 6) begin bad++; $display("FAIL lw_wait_cycles got=%0d want=6", waits); end
    endtask

    task automatic test_branch();
        for (int k = 0; k < 2; k++) begin
            prep();
            imem[0] = enc_i(6'h08, 0, 1, 1);
            imem[1] = enc_i(6'h08, 0, 2, 2);
            imem[2] = (k == 0) ? enc_i(6'h04, 1, 1, 2) : enc_i(6'h04, 1, 2, 2);
            exp_fa_q.push_back(8'h00);
            exp_fa_q.push_back(8'h04);
            exp_fa_q.push_back(8'h08);
            exp_fa_q.push_back((k == 0) ? 8'h14 : 8'h0C);
            exp_lat_q.push_back(4);
            exp_lat_q.push_back(4);
            exp_lat_q.push_back(3);
            release_reset();
            for (int i = 0; i < 100 && !halted; i++) begin @(posedge clk); #1; end
            total++; if (halted !== 1'b1) begin bad++; $display("FAIL beq%0d_timeout halted=%b want=1", k, halted); end
            for (int i = 0; i < exp_fa_q.size(); i++) begin
                total++;
                if (i >= fa_q.size()) begin bad++; $display("FAIL beq%0d_fetch[%0d] got=none want=%h", k, i, exp_fa_q[i]); end
                else if (fa_q[i] !== exp_fa_q[i]) begin bad++; $display("FAIL beq%0d_fetch[%0d] got=%h want=%h", k, i, fa_q[i], exp_fa_q[i]); end
            end
            for (int i = 0; i < exp_lat_q.size(); i++) begin
                total++;
                if (i + 1 >= fc_q.size()) begin bad++; $display("FAIL beq%0d_lat[%0d] got=none want=%0d", k, i, exp_lat_q[i]); end
                else if (fc_q[i+1] - fc_q[i] != exp_lat_q[i]) begin bad++; $display("FAIL beq%0d_lat[%0d] got=%0d want=%0d", k, i, fc_q[i+1] - fc_q[i], exp_lat_q[i]); end
            end
        end
    endtask

    task automatic test_wrap_zero();
        logic [39:0] o;
        prep();
        imem[0]  = enc_j(26'h3F);
        imem[63] = enc_i(6'h08, 0, 0, 7);
        exp_fa_q.push_back(8'h00);
        exp_fa_q.push_back(8'hFC);
        exp_fa_q.push_back(8'h00);
        exp_fa_q.push_back(8'h04);
        exp_lat_q.push_back(3);
        exp_lat_q.push_back(4);
        exp_lat_q.push_back(4);
        release_reset();
        for (int i = 0; i < 100 && fa_q.size() < 2; i++) begin @(posedge clk); #1; end
        // Replace the jump so the second pass stores $0 and stops.
        imem[0] = enc_i(6'h2B, 0, 0, 128);
        imem[1] = HALT_W;
        for (int i = 0; i < 100 && !halted; i++) begin @(posedge clk); #1; end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL wrap_timeout halted=%b want=1", halted); end
        for (int i = 0; i < exp_fa_q.size(); i++) begin
            total++;
            if (i >= fa_q.size()) begin bad++; $display("FAIL wrap_fetch[%0d] got=none want=%h", i, exp_fa_q[i]); end
            else if (fa_q[i] !== exp_fa_q[i]) begin bad++; $display("FAIL wrap_fetch[%0d] got=%h want=%h", i, fa_q[i], exp_fa_q[i]); end
        end
        for (int i = 0; i < exp_lat_q.size(); i++) begin
            total++;
            if (i + 1 >= fc_q.size()) begin bad++; $display("FAIL wrap_lat[%0d] got=none want=%0d", i, exp_lat_q[i]); end
            else if (fc_q[i+1] - fc_q[i] != exp_lat_q[i]) begin bad++; $display("FAIL wrap_lat[%0d] got=%0d want=%0d", i, fc_q[i+1] - fc_q[i], exp_lat_q[i]); end
        end
        total++;
        if (wr_q.size() == 0) begin bad++; $display("FAIL r0_write got=none want=%h", {8'h80, 32'h0}); end
        else begin
            o = wr_q.pop_front();
            if (o !== {8'h80, 32'h0}) begin bad++; $display("FAIL r0_write got=%h want=%h", o, {8'h80, 32'h0}); end
        end
    endtask

    task automatic test_halt();
        int c0;
        int nreq;
        for (int k = 0; k < 2; k++) begin
            prep();
            imem[0] = (k == 0) ? HALT_W : enc_r(1, 2, 3, 6'h00);
            release_reset();
            c0 = cyc;
            for (int i = 0; i < 50 && !halted; i++) begin @(posedge clk); #1; end
            total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt%0d_set got=%b want=1", k, halted); end
            total++; if (cyc - c0 != 2) begin bad++; $display("FAIL halt%0d_cycles got=%0d want=2", k, cyc - c0); end
            total++; if (state !== 3'd5) begin bad++; $display("FAIL halt%0d_state got=%0d want=5", k, state); end
            nreq = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (mem_req) nreq++;
            end
            total++; if (nreq != 0) begin bad++; $display("FAIL halt%0d_reqs got=%0d want=0", k, nreq); end
            total++; if (pc !== 8'h04) begin bad++; $display("FAIL halt%0d_pc got=%h want=04", k, pc); end
            total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt%0d_sticky got=%b want=1", k, halted); end
        end
        prep();
        #1;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_cleared got=%b want=0", halted); end
    endtask

    task automatic test_reset_mid();
        logic [39:0] o;
        prep();
        data_delay = 100000;
        imem[0] = enc_i(6'h08, 0, 1, 9);
        imem[1] = enc_i(6'h2B, 0, 1, 64);
        release_reset();
        for (int i = 0; i < 50 && state !== 3'd3; i++) begin @(posedge clk); #1; end
        total++; if (state !== 3'd3) begin bad++; $display("FAIL mid_reach_mem state=%0d want=3", state); end
        repeat (2) @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_req got=%b want=0", mem_req); end
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL mid_pc got=%h want=00", pc); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL mid_state got=%0d want=0", state); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL mid_halted got=%b want=0", halted); end
        total++; if (wr_q.size() != 0) begin bad++; $display("FAIL mid_no_write got=%0d want=0", wr_q.size()); end
        // Registers must be cleared by the reset: storing $1 now yields zero.
        prep();
        imem[0] = enc_i(6'h2B, 0, 1, 64);
        release_reset();
        for (int i = 0; i < 50 && !halted; i++) begin @(posedge clk); #1; end
        total++;
        if (wr_q.size() == 0) begin bad++; $display("FAIL mid_reg_clear got=none want=%h", {8'h40, 32'h0}); end
        else begin
            o = wr_q.pop_front();
            if (o !== {8'h40, 32'h0}) begin bad++; $display("FAIL mid_reg_clear got=%h want=%h", o, {8'h40, 32'h0}); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw_wait();
        test_branch();
        test_wrap_zero();
        test_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
